// File: rtl/num_syst_conv_pkg.sv
// Shared definitions for the number-system display block: 7-segment glyphs
// (segments gfedcba, active-high), converter FSM states and a width helper.
package num_syst_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/num_syst_conv_seg7.sv
// Combinational 4-bit to 7-segment lookup with a blanking input.
module seg7_decoder
    import num_syst_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup; blank overrides the value.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (value)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                4'hF:    seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/num_syst_conv.sv
// Switch word display: live LED/hex mirror plus a key-triggered sequential
// binary-to-decimal (double-dabble) conversion with sign and zero blanking.
module num_syst_conv
    import num_syst_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int HEX_DIGITS = (IN_W + 3) / 4,
    parameter int DEC_DIGITS = 3,
    parameter int DEB_CYC    = 16
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_conv_n,
    input  logic                    key_clr_n,
    input  logic                    signed_mode,
    input  logic [IN_W-1:0]         switches,
    output logic [IN_W-1:0]         ledr,
    output logic [7*HEX_DIGITS-1:0] hex_seg,
    output logic [7*DEC_DIGITS-1:0] dec_seg,
    output logic [6:0]              sign_seg,
    output logic                    busy,
    output logic                    done
);

    localparam int BCD_W     = 4 * DEC_DIGITS;
    localparam int HEX_W     = 4 * HEX_DIGITS;
    localparam int BIT_CNT_W = (clog2(IN_W) < 1) ? 1 : clog2(IN_W);
    localparam int DEB_W     = (clog2(DEB_CYC + 1) < 1) ? 1 : clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0]     DEB_LAST = DEB_W'((DEB_CYC > 0) ? DEB_CYC - 1 : 0);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(IN_W - 1);
    localparam logic [7*HEX_DIGITS-1:0] HEX_RESET = {HEX_DIGITS{SEG_0}};
    localparam logic [7*DEC_DIGITS-1:0] DEC_RESET = {{(7*DEC_DIGITS-7){1'b0}}, SEG_0};

    if (IN_W < 4 || IN_W > 32) begin : g_bad_in_w
        $error("num_syst_conv: IN_W must be in 4..32");
    end
    if ((64'd10 ** DEC_DIGITS) <= (64'd1 << IN_W)) begin : g_bad_dec_digits
        $error("num_syst_conv: DEC_DIGITS too small for IN_W");
    end

    // ---------------- key synchronisers, debounce filters, press pulses
    logic [1:0] keys_n_s;
    logic [1:0] press_s;
    assign keys_n_s = {key_clr_n, key_conv_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             sync1_r;
        logic             sync2_r;
        logic             filt_r;
        logic             press_r;
        logic [DEB_W-1:0] cnt_r;
        logic             filt_nxt_s;
        logic [DEB_W-1:0] cnt_nxt_s;

        // Filter adopts the synced level once it has disagreed for DEB_CYC cycles.
        always_comb begin
            filt_nxt_s = filt_r;
            cnt_nxt_s  = {DEB_W{1'b0}};
            if (sync2_r != filt_r) begin
                if (DEB_CYC == 0 || cnt_r == DEB_LAST) begin
                    filt_nxt_s = sync2_r;
                    cnt_nxt_s  = {DEB_W{1'b0}};
                end else begin
                    cnt_nxt_s  = cnt_r + 1'b1;
                end
            end else begin
                cnt_nxt_s = {DEB_W{1'b0}};
            end
        end

        // Two-flop synchroniser, filter state and registered falling-edge pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_r <= 1'b1;
                sync2_r <= 1'b1;
                filt_r  <= 1'b1;
                cnt_r   <= {DEB_W{1'b0}};
                press_r <= 1'b0;
            end else begin
                sync1_r <= keys_n_s[k];
                sync2_r <= sync1_r;
                filt_r  <= filt_nxt_s;
                cnt_r   <= cnt_nxt_s;
                press_r <= filt_r & ~filt_nxt_s;
            end
        end

        assign press_s[k] = press_r;
    end

    logic conv_press_s;
    logic clr_press_s;
    assign conv_press_s = press_s[0];
    assign clr_press_s  = press_s[1];

    // ---------------- live LED / hex path
    logic [HEX_W-1:0]        hex_in_s;
    logic [7*HEX_DIGITS-1:0] hex_dec_s;
    assign hex_in_s = HEX_W'(switches);

    for (genvar h = 0; h < HEX_DIGITS; h++) begin : g_hex
        seg7_decoder u_hex_dec (
            .value (hex_in_s[4*h +: 4]),
            .blank (1'b0),
            .seg   (hex_dec_s[7*h +: 7])
        );
    end

    // Mirror switches to LEDs and hex digits with one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr    <= {IN_W{1'b0}};
            hex_seg <= HEX_RESET;
        end else begin
            ledr    <= switches;
            hex_seg <= hex_dec_s;
        end
    end

    // ---------------- double-dabble datapath
    state_t                 state_r;
    logic [BCD_W-1:0]       bcd_r;
    logic [IN_W-1:0]        opd_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic                   neg_r;
    logic                   snap_neg_s;
    logic [IN_W-1:0]        snap_opd_s;
    logic [BCD_W-1:0]       bcd_adj_s;
    logic [BCD_W-1:0]       bcd_nxt_s;
    logic [IN_W-1:0]        opd_nxt_s;
    logic [DEC_DIGITS-1:0]  dec_blank_s;
    logic [7*DEC_DIGITS-1:0] dec_dec_s;
    logic                   lead_s;

    // Snapshot operand: unsigned magnitude of the word (|-2**(IN_W-1)| still fits IN_W bits).
    always_comb begin
        snap_neg_s = signed_mode & switches[IN_W-1];
        if (snap_neg_s) begin
            snap_opd_s = ~switches + 1'b1;
        end else begin
            snap_opd_s = switches;
        end
    end

    // One double-dabble step: +3 on nibbles >= 5, then shift {bcd, operand} left.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int d = 0; d < DEC_DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4];
            end
        end
        {bcd_nxt_s, opd_nxt_s} = {bcd_adj_s, opd_r} << 1;
    end

    // Leading-zero blanking of the step result; units digit always shown.
    always_comb begin
        dec_blank_s = {DEC_DIGITS{1'b0}};
        lead_s      = 1'b1;
        for (int d = DEC_DIGITS - 1; d > 0; d--) begin
            if (bcd_nxt_s[4*d +: 4] != 4'd0) begin
                lead_s = 1'b0;
            end else begin
                lead_s = lead_s;
            end
            dec_blank_s[d] = lead_s;
        end
    end

    for (genvar g = 0; g < DEC_DIGITS; g++) begin : g_dec
        seg7_decoder u_dec_dec (
            .value (bcd_nxt_s[4*g +: 4]),
            .blank (dec_blank_s[g]),
            .seg   (dec_dec_s[7*g +: 7])
        );
    end

    // Converter FSM; the final shift result is decoded and loaded on entry to LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            bcd_r     <= {BCD_W{1'b0}};
            opd_r     <= {IN_W{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dec_seg   <= DEC_RESET;
            sign_seg  <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            if (clr_press_s) begin
                state_r  <= IDLE;
                busy     <= 1'b0;
                dec_seg  <= DEC_RESET;
                sign_seg <= SEG_BLANK;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (conv_press_s) begin
                            opd_r     <= snap_opd_s;
                            neg_r     <= snap_neg_s;
                            bcd_r     <= {BCD_W{1'b0}};
                            bit_cnt_r <= BIT_LAST;
                            busy      <= 1'b1;
                            state_r   <= CONV;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end
                    CONV: begin
                        bcd_r <= bcd_nxt_s;
                        opd_r <= opd_nxt_s;
                        if (bit_cnt_r == {BIT_CNT_W{1'b0}}) begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            dec_seg  <= dec_dec_s;
                            sign_seg <= neg_r ? SEG_MINUS : SEG_BLANK;
                            state_r  <= LOAD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 1'b1;
                        end
                    end
                    LOAD: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_num_syst_conv.sv
// Self-checking bench: scoreboard of expected decimal results checked on done.
module tb_num_syst_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic        signed_mode;
    logic [7:0]  switches;
    logic        key_conv0_n, key_clr0_n, key_conv16_n, key_clr16_n;

    logic [7:0]  ledr0, ledr16;
    logic [13:0] hex_seg0, hex_seg16;
    logic [20:0] dec_seg0, dec_seg16;
    logic [6:0]  sign_seg0, sign_seg16;
    logic        busy0, busy16, done0, done16;

    int checks = 0;
    int errors = 0;
    int done0_cnt = 0;
    int done16_cnt = 0;
    logic busy16_seen = 1'b0;
    logic [27:0] q0[$];
    logic [27:0] q16[$];
    logic [27:0] exp0, exp16;

    localparam logic [20:0] DEC_RST = {7'b0000000, 7'b0000000, 7'b0111111};

    always #5 clk = ~clk;

    num_syst_conv #(.IN_W(8), .DEC_DIGITS(3), .DEB_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .key_conv_n(key_conv0_n), .key_clr_n(key_clr0_n),
        .signed_mode(signed_mode), .switches(switches), .ledr(ledr0), .hex_seg(hex_seg0),
        .dec_seg(dec_seg0), .sign_seg(sign_seg0), .busy(busy0), .done(done0)
    );

    num_syst_conv #(.IN_W(8), .DEC_DIGITS(3), .DEB_CYC(16)) dut16 (
        .clk(clk), .reset(reset), .key_conv_n(key_conv16_n), .key_clr_n(key_clr16_n),
        .signed_mode(signed_mode), .switches(switches), .ledr(ledr16), .hex_seg(hex_seg16),
        .dec_seg(dec_seg16), .sign_seg(sign_seg16), .busy(busy16), .done(done16)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected {sign_seg, dec_seg} for a snapshot.
    function automatic logic [27:0] model(input logic [7:0] sw, input logic sm);
        logic neg;
        int v, h, t, u;
        logic [6:0] gh, gt;
        neg = sm & sw[7];
        v = neg ? 256 - int'(sw) : int'(sw);
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        gh = (h == 0) ? 7'b0000000 : glyph(h);
        gt = (h == 0 && t == 0) ? 7'b0000000 : glyph(t);
        return {neg ? 7'b1000000 : 7'b0000000, gh, gt, glyph(u)};
    endfunction

    // Scoreboard: pop and compare whenever a DUT reports done.
    always @(negedge clk) begin
        if (busy16) busy16_seen = 1'b1;
        if (done0) begin
            done0_cnt++;
            check_eq("dut0_done_expected", (q0.size() != 0), 1'b1);
            if (q0.size() != 0) begin
                exp0 = q0.pop_front();
                check_eq("dut0_result", {sign_seg0, dec_seg0}, exp0);
            end
        end
        if (done16) begin
            done16_cnt++;
            check_eq("dut16_done_expected", (q16.size() != 0), 1'b1);
            if (q16.size() != 0) begin
                exp16 = q16.pop_front();
                check_eq("dut16_result", {sign_seg16, dec_seg16}, exp16);
            end
        end
    end

    task automatic wait_busy0(input string tag);
        int t;
        t = 0;
        while (!busy0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, busy0, 1'b1);
    endtask

    task automatic do_conv0(input logic [7:0] sw, input logic sm);
        int t, busy_cyc;
        logic flipped;
        @(negedge clk);
        switches = sw;
        signed_mode = sm;
        q0.push_back(model(sw, sm));
        key_conv0_n = 1'b0;
        t = 0;
        busy_cyc = 0;
        flipped = 1'b0;
        while (t < 60) begin
            @(negedge clk);
            t++;
            if (t == 3) key_conv0_n = 1'b1;
            if (busy0) begin
                busy_cyc++;
                if (!flipped) begin
                    switches = ~sw;
                    signed_mode = ~sm;
                    flipped = 1'b1;
                end
            end
            if (done0) break;
        end
        key_conv0_n = 1'b1;
        check_eq("conv_done_seen", done0, 1'b1);
        check_eq("busy_cycles", busy_cyc, 8);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int d;
        logic bseen;
        reset = 1'b1;
        key_conv0_n = 1'b1; key_clr0_n = 1'b1;
        key_conv16_n = 1'b1; key_clr16_n = 1'b1;
        signed_mode = 1'b0;
        switches = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_ledr", ledr0, 8'h00);
        check_eq("rst_hex", hex_seg0, {7'b0111111, 7'b0111111});
        check_eq("rst_dec", dec_seg0, DEC_RST);
        check_eq("rst_sign", sign_seg0, 7'b0000000);
        check_eq("rst_busy_done", {busy0, done0, busy16, done16}, 4'b0000);
        reset = 1'b0;

        // Live path
        @(negedge clk);
        switches = 8'hA7;
        @(negedge clk);
        check_eq("live_ledr", ledr0, 8'hA7);
        check_eq("live_hex", hex_seg0, {7'b1110111, 7'b0000111});

        // Conversions
        do_conv0(8'hA7, 1'b0);
        do_conv0(8'hA7, 1'b1);
        do_conv0(8'h80, 1'b1);
        do_conv0(8'h05, 1'b0);
        do_conv0(8'h00, 1'b0);
        do_conv0(8'hFF, 1'b0);
        do_conv0(8'h7B, 1'b1);

        // Clear during CONV
        @(negedge clk);
        switches = 8'h64;
        signed_mode = 1'b0;
        key_conv0_n = 1'b0;
        wait_busy0("abort_busy_seen");
        key_conv0_n = 1'b1;
        key_clr0_n = 1'b0;
        d = done0_cnt;
        repeat (3) @(negedge clk);
        key_clr0_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("abort_busy", busy0, 1'b0);
        check_eq("abort_no_done", done0_cnt, d);
        check_eq("abort_dec", {sign_seg0, dec_seg0}, {7'b0000000, DEC_RST});

        // Simultaneous conv and clear
        do_conv0(8'h2A, 1'b0);
        @(negedge clk);
        key_conv0_n = 1'b0;
        key_clr0_n = 1'b0;
        d = done0_cnt;
        bseen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                key_conv0_n = 1'b1;
                key_clr0_n = 1'b1;
            end
            if (busy0) bseen = 1'b1;
        end
        check_eq("simul_no_busy", bseen, 1'b0);
        check_eq("simul_no_done", done0_cnt, d);
        check_eq("simul_dec", dec_seg0, DEC_RST);

        // Async reset mid-conversion
        @(negedge clk);
        switches = 8'hC3;
        signed_mode = 1'b1;
        key_conv0_n = 1'b0;
        wait_busy0("rstconv_busy_seen");
        key_conv0_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_ledr", ledr0, 8'h00);
        check_eq("arst_hex", hex_seg0, {7'b0111111, 7'b0111111});
        check_eq("arst_dec", {sign_seg0, dec_seg0}, {7'b0000000, DEC_RST});
        check_eq("arst_busy_done", {busy0, done0}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_conv0(8'hC3, 1'b1);

        // Debounce on dut16
        switches = 8'h9C;
        signed_mode = 1'b0;
        busy16_seen = 1'b0;
        @(negedge clk);
        key_conv16_n = 1'b0;
        repeat (10) @(negedge clk);
        key_conv16_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_no_done", done16_cnt, 0);
        check_eq("glitch_no_busy", busy16_seen, 1'b0);

        q16.push_back(model(8'h9C, 1'b0));
        key_conv16_n = 1'b0;
        repeat (20) @(negedge clk);
        key_conv16_n = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("press20_one_conv", done16_cnt, 1);

        q16.push_back(model(8'h9C, 1'b0));
        key_conv16_n = 1'b0;
        repeat (1000) @(negedge clk);
        key_conv16_n = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("hold1000_one_conv", done16_cnt, 2);

        check_eq("q0_drained", q0.size(), 0);
        check_eq("q16_drained", q16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/num_syst_conv.md
Name: num_syst_conv

Overview:
Parametrised successor to the board-level number-system display block. It mirrors an IN_W-bit switch word onto LEDs and shows it live in hexadecimal on 7-segment digits. On a debounced key press it snapshots the word and converts it to decimal with a sequential double-dabble engine, one bit per clock. The decimal result supports optional signed mode and leading-zero blanking. The block sits between the board pins (keys, switches) and the 7-segment/LED outputs in the top level.

Parameters:
IN_W, 8, switch word width (4..32)
HEX_DIGITS, (IN_W+3)/4, number of hex display digits
DEC_DIGITS, 3, number of decimal digits; elaboration error if 10**DEC_DIGITS <= 2**IN_W
DEB_CYC, 16, debounce stability count in clk cycles (0 = no debounce)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_conv_n  in  1  convert button, active-low, asynchronous to clk
key_clr_n  in  1  clear button, active-low, asynchronous to clk
signed_mode  in  1  1 = interpret snapshot as two's complement
switches  in  IN_W  input word
ledr  out  IN_W  registered copy of switches
hex_seg  out  7*HEX_DIGITS  hex digits, digit 0 = LSN in bits [6:0], segments gfedcba active-high
dec_seg  out  7*DEC_DIGITS  decimal digits, digit 0 = units in bits [6:0]
sign_seg  out  7  minus glyph (7'b1000000) or blank (7'b0000000)
busy  out  1  high while conversion runs
done  out  1  one-cycle pulse when the decimal result updates

Behaviour:
- Reset: ledr=0; every hex_seg digit = '0' (7'b0111111); dec_seg digit 0 = '0', other digits blank; sign_seg blank; busy=0; done=0; FSM=IDLE; debounce filters = 1 (released).
- Key path, per key: 2-flop synchroniser, then a debounce filter. The filtered level takes the synced value after that value has differed from it for DEB_CYC consecutive cycles; the counter clears on any agreement. A press is a registered 1-cycle pulse on the filtered 1->0 edge.
- With DEB_CYC=0, the press pulse is asserted 3 clk edges after the key is sampled low.
- Live path: ledr and hex_seg are registered from switches, 1-cycle latency. The hex path is unaffected by the FSM and by clear.
- FSM IDLE:
  - On conv press: snapshot switches.
  - If signed_mode=1 and the snapshot MSB is 1, operand = two's-complement magnitude (IN_W+1-bit safe, so -2**(IN_W-1) is correct) and neg=1; otherwise neg=0.
  - Clear BCD register; bit counter = IN_W-1; busy=1; go to CONV.
- FSM CONV: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, operand} left 1. After IN_W shift cycles, go to LOAD. Conversion takes exactly IN_W cycles in CONV.
- FSM LOAD (1 cycle):
  - Decode the BCD to dec_seg with leading-zero blanking; digit 0 is never blanked.
  - sign_seg = minus if neg, else blank.
  - done=1 for this cycle; busy=0 on the next cycle; return to IDLE.
- Conv press while in CONV or LOAD: ignored, not queued.
- Clr press in any state: abort conversion; dec_seg = reset value; sign_seg blank; busy=0; FSM=IDLE; no done pulse.
- Simultaneous conv and clr press: clear wins.
- signed_mode and switches are sampled only at the snapshot. Later changes do not affect an ongoing conversion.
- Asynchronous reset mid-conversion returns all state to reset values immediately.

Decomposition:
- Package num_syst_pkg: 7-segment glyph constants SEG_0..SEG_F, SEG_MINUS, SEG_BLANK; FSM state enum (IDLE, CONV, LOAD); function clog2.
- Sub-module seg7_decoder: combinational 4-bit to 7-segment lookup using the package constants, with a blank input. Instantiated once per hex digit and once per decimal digit.
- The debouncer stays inline (one generate loop over two keys) unless it is reused elsewhere.

Test Plan:
1. IN_W=8, DEB_CYC=0, switches=8'hA7 -> after 1 clk, hex_seg digit1=7'b1110111 ('A'), digit0=7'b0000111 ('7'), ledr=8'hA7. Press conv -> busy high 8 cycles, then done pulse; dec_seg = '1','6','7' (7'b0000110, 7'b1111101, 7'b0000111); sign blank.
2. signed_mode=1, switches=8'hA7 -> sign_seg=7'b1000000; dec_seg = blank, '8' (7'b1111111), '9' (7'b1101111). Separately, switches=8'h80 -> '-','1','2','8'.
3. switches=8'h05, unsigned -> dec_seg digit2, digit1 blank, digit0='5' (7'b1101101). switches=8'h00 -> digit0='0' only. switches=8'hFF -> '2','5','5'.
4. Press conv, then press clr 3 cycles into CONV -> busy drops, no done pulse, dec_seg shows reset pattern. Conv and clr pressed in the same cycle -> clear behaviour, FSM stays IDLE.
5. DEB_CYC=16: key_conv_n low glitch of 10 cycles -> no conversion. Low for 20 cycles -> exactly one conversion. Holding the key low for 1000 cycles -> still one conversion.
6. Assert reset during CONV -> all outputs return to reset values asynchronously. After release, a new conv press converts correctly.
